// File: rtl/multi_core_reset_sequencer.sv
// Core reset sequencer: applies pulse/assert/release commands to a set of core reset lines,
// enforcing a minimum hold and releasing masked cores one at a time in ascending index order.
module multi_core_reset_sequencer #(
    parameter int NUM_CORES = 4,
    parameter int HOLD_W    = 16,
    parameter int MIN_HOLD  = 8,
    parameter int STAGGER   = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [NUM_CORES-1:0] cmd_mask,
    input  logic [HOLD_W-1:0]    cmd_hold,
    output logic [NUM_CORES-1:0] core_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int STG_W = $clog2(STAGGER + 1);
    localparam logic [STG_W-1:0]  STG_LOAD   = STG_W'(STAGGER);
    localparam logic [HOLD_W-1:0] MIN_HOLD_V = HOLD_W'(MIN_HOLD);

    localparam logic [1:0] OP_PULSE   = 2'd0;
    localparam logic [1:0] OP_ASSERT  = 2'd1;
    localparam logic [1:0] OP_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [NUM_CORES-1:0]  r_core_reset;
    logic [NUM_CORES-1:0]  w_core_nx;
    logic [NUM_CORES-1:0]  r_pending;
    logic [NUM_CORES-1:0]  w_pend_nx;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_nx;
    logic [STG_W-1:0]      r_stg_cnt;
    logic [STG_W-1:0]      w_stg_nx;
    logic                  r_done;
    logic                  w_done_nx;
    logic                  r_err;
    logic                  w_err_nx;
    logic                  w_rel_go;
    logic [NUM_CORES-1:0]  w_rel_src;
    logic [NUM_CORES-1:0]  w_rel_low;
    logic [NUM_CORES-1:0]  w_rel_rem;
    logic [HOLD_W-1:0]     w_hold_eff;

    // Isolates the lowest set bit, i.e. the next core due for release.
    function automatic logic [NUM_CORES-1:0] lowest_bit(input logic [NUM_CORES-1:0] v);
        return v & (~v + NUM_CORES'(1));
    endfunction

    assign w_hold_eff = (cmd_hold < MIN_HOLD_V) ? MIN_HOLD_V : cmd_hold;
    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign core_reset = r_core_reset;
    assign done       = r_done;
    assign err        = r_err;

    // Next-state and datapath decode; a release step is shared by accept, hold expiry and stagger expiry.
    always_comb begin
        w_state_nx = r_state;
        w_core_nx  = r_core_reset;
        w_pend_nx  = r_pending;
        w_hold_nx  = r_hold_cnt;
        w_stg_nx   = r_stg_cnt;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_rel_go   = 1'b0;
        w_rel_src  = '0;
        w_rel_low  = '0;
        w_rel_rem  = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PULSE: begin
                            if (cmd_mask == '0) begin
                                w_done_nx  = 1'b1;
                                w_state_nx = ST_FINISH;
                            end else begin
                                w_core_nx  = r_core_reset | cmd_mask;
                                w_pend_nx  = cmd_mask;
                                w_hold_nx  = w_hold_eff;
                                w_state_nx = ST_HOLD;
                            end
                        end
                        OP_ASSERT: begin
                            w_core_nx  = r_core_reset | cmd_mask;
                            w_done_nx  = 1'b1;
                            w_state_nx = ST_FINISH;
                        end
                        OP_RELEASE: begin
                            // Cores already out of reset take no release slot.
                            w_rel_go  = 1'b1;
                            w_rel_src = cmd_mask & r_core_reset;
                        end
                        default: begin
                            w_err_nx   = 1'b1;
                            w_done_nx  = 1'b1;
                            w_state_nx = ST_FINISH;
                        end
                    endcase
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt <= HOLD_W'(1)) begin
                    w_hold_nx = '0;
                    w_rel_go  = 1'b1;
                    w_rel_src = r_pending;
                end else begin
                    w_hold_nx = r_hold_cnt - HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (r_stg_cnt <= STG_W'(1)) begin
                    w_stg_nx  = '0;
                    w_rel_go  = 1'b1;
                    w_rel_src = r_pending;
                end else begin
                    w_stg_nx = r_stg_cnt - STG_W'(1);
                end
            end
            ST_FINISH: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
        if (w_rel_go) begin
            w_rel_low = lowest_bit(w_rel_src);
            w_rel_rem = w_rel_src & ~w_rel_low;
            w_core_nx = r_core_reset & ~w_rel_low;
            w_pend_nx = w_rel_rem;
            if (w_rel_rem == '0) begin
                w_done_nx  = 1'b1;
                w_state_nx = ST_FINISH;
            end else begin
                w_stg_nx   = STG_LOAD;
                w_state_nx = ST_RELEASE;
            end
        end else begin
            w_rel_low = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath registers; reset holds every core in reset and drops any command in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_core_reset <= '1;
            r_pending    <= '0;
            r_hold_cnt   <= '0;
            r_stg_cnt    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_core_reset <= w_core_nx;
            r_pending    <= w_pend_nx;
            r_hold_cnt   <= w_hold_nx;
            r_stg_cnt    <= w_stg_nx;
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
        end
    end

endmodule

// File: tb/tb_multi_core_reset_sequencer.sv
// Bench for multi_core_reset_sequencer: a per-cycle expected trace is queued at each accept
// and popped/compared against {core_reset, done, err, cmd_ready, busy} cycle by cycle.
module tb_multi_core_reset_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_mask;
    logic [15:0] cmd_hold;
    logic [3:0]  core_reset;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  m_core;
    logic [7:0]  exp_q[$];

    multi_core_reset_sequencer #(
        .NUM_CORES(4), .HOLD_W(16), .MIN_HOLD(8), .STAGGER(2)
    ) dut (
        .clock(clk), .reset_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_hold(cmd_hold),
        .core_reset(core_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: list each core's release cycle, then expand into a per-cycle trace.
    task automatic predict(input logic [1:0] op, input logic [3:0] mask, input logic [15:0] hold);
        logic [3:0] base;
        logic [3:0] pend;
        logic [3:0] c;
        logic       err_e;
        int         rel_t[4];
        int         hh;
        int         k;
        int         last;
        base = m_core; pend = 4'b0000; hh = 0; err_e = 1'b0; k = 0; last = 1;
        for (int i = 0; i < 4; i++) rel_t[i] = 0;
        case (op)
            2'd0: if (mask != 4'b0000) begin
                base = m_core | mask;
                pend = mask;
                hh   = (hold < 16'd8) ? 8 : int'(hold);
            end
            2'd1: base = m_core | mask;
            2'd2: pend = mask & m_core;
            default: err_e = 1'b1;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                rel_t[i] = hh + 1 + 2 * k;
                last = rel_t[i];
                k++;
            end
        end
        for (int j = 1; j <= last + 1; j++) begin
            c = base;
            for (int i = 0; i < 4; i++) if (pend[i] && j >= rel_t[i]) c[i] = 1'b0;
            exp_q.push_back({c, (j == last), (err_e && j == 1), (j == last + 1), (j != last + 1)});
        end
        m_core = base & ~pend;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] mask, input logic [15:0] hold);
        int waited;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL issue_wait_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        cmd_op = op; cmd_mask = mask; cmd_hold = hold; cmd_valid = 1'b1;
        predict(op, mask, hold);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_mask  = 4'($urandom);
        cmd_hold  = 16'($urandom);
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_mask = 4'd0; cmd_hold = 16'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {core_reset, done, err, cmd_ready, busy};
            n_checks++;
            if (got !== 8'b1111_0_0_1_0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %b required %b (core,done,err,ready,busy)", i, got, 8'b1111_0_0_1_0);
            end
        end
        rst_n  = 1'b1;
        m_core = 4'b1111;
        @(negedge clk);
    endtask

    task automatic test_power_on_release();
        logic [7:0] got;
        logic [7:0] e;
        int         j;
        issue(2'd2, 4'b1111, 16'd0);
        j = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = {core_reset, done, err, cmd_ready, busy};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL power_on_release T+%0d: got %b required %b (core,done,err,ready,busy)", j, got, e);
            end
            j++;
        end
    endtask

    task automatic test_pulse();
        logic [7:0]  got;
        logic [7:0]  e;
        logic [3:0]  masks[2] = '{4'b0101, 4'b1000};
        logic [15:0] holds[2] = '{16'd3, 16'd20};
        for (int r = 0; r < 2; r++) begin
            issue(2'd0, masks[r], holds[r]);
            for (int j = 1; exp_q.size() > 0; j++) begin
                @(negedge clk);
                got = {core_reset, done, err, cmd_ready, busy};
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL pulse%0d T+%0d: got %b required %b (core,done,err,ready,busy)", r, j, got, e);
                end
            end
        end
    endtask

    task automatic test_skip_empty();
        logic [7:0] got;
        logic [7:0] e;
        logic [1:0] ops[4]   = '{2'd1, 2'd2, 2'd2, 2'd0};
        logic [3:0] masks[4] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000};
        for (int r = 0; r < 4; r++) begin
            issue(ops[r], masks[r], 16'd5);
            for (int j = 1; exp_q.size() > 0; j++) begin
                @(negedge clk);
                got = {core_reset, done, err, cmd_ready, busy};
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL skip_empty%0d T+%0d: got %b required %b (core,done,err,ready,busy)", r, j, got, e);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] got;
        logic [7:0] e;
        logic [3:0] masks[2] = '{4'b1111, 4'b0110};
        for (int r = 0; r < 2; r++) begin
            issue(2'd3, masks[r], 16'd9);
            for (int j = 1; exp_q.size() > 0; j++) begin
                @(negedge clk);
                got = {core_reset, done, err, cmd_ready, busy};
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL illegal%0d T+%0d: got %b required %b (core,done,err,ready,busy)", r, j, got, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] e;
        cmd_op = 2'd1; cmd_mask = 4'b0001; cmd_hold = 16'd0; cmd_valid = 1'b1;
        m_core = m_core | 4'b0001;
        for (int j = 1; j <= 6; j++) begin
            if (j % 2 == 1) exp_q.push_back({m_core, 4'b1001});
            else            exp_q.push_back({m_core, 4'b0010});
        end
        @(posedge clk);
        for (int j = 1; exp_q.size() > 0; j++) begin
            @(negedge clk);
            if (j == 6) cmd_valid = 1'b0;
            got = {core_reset, done, err, cmd_ready, busy};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back T+%0d: got %b required %b (core,done,err,ready,busy)", j, got, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got;
        logic [7:0] e;
        issue(2'd0, 4'b0110, 16'd10);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            got = {core_reset, done, err, cmd_ready, busy};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mid_reset_hold T+%0d: got %b required %b (core,done,err,ready,busy)", j, got, e);
            end
        end
        exp_q.delete();
        rst_n = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 1) rst_n = 1'b1;
            got = {core_reset, done, err, cmd_ready, busy};
            n_checks++;
            if (got !== 8'b1111_0_0_1_0) begin
                n_fail++;
                $display("FAIL mid_reset_after cyc %0d: got %b required %b (core,done,err,ready,busy)", j, got, 8'b1111_0_0_1_0);
            end
        end
        m_core = 4'b1111;
    endtask

    initial begin
        test_reset();
        test_power_on_release();
        test_pulse();
        test_skip_empty();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/multi_core_reset_sequencer.md
# multi_core_reset_sequencer

Parametrised, synthesizable successor to the single-value core reset hook in the SiFive E21 testbench. It holds up to `NUM_CORES` core reset lines and applies commands received over a valid/ready interface. Each command pulses, asserts or releases a masked subset of cores. Every hold meets a minimum duration, and cores release staggered in ascending index order. The block sits in the testbench/SoC reset path between the test controller (or a DPI shim) and the core reset inputs.

## Interface
Parameters:
- `NUM_CORES`, 4: number of core reset outputs (1..32).
- `HOLD_W`, 16: width of the hold-cycle field.
- `MIN_HOLD`, 8: minimum assert duration in cycles (≥1, < 2^HOLD_W).
- `STAGGER`, 2: cycles between successive core releases (≥1).

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block idle and able to accept a command.
- `cmd_op`  in  2  0=PULSE, 1=ASSERT, 2=RELEASE, 3=illegal.
- `cmd_mask`  in  NUM_CORES  cores targeted; bit i = core i.
- `cmd_hold`  in  HOLD_W  requested hold cycles; used by PULSE only.
- `core_reset`  out  NUM_CORES  active-high reset to each core.
- `busy`  out  1  equals `!cmd_ready`.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse when an illegal op is accepted.

## Operation
- Reset (`reset_n`=0 at an edge):
  - `core_reset` = all ones; the cores power up held in reset.
  - `cmd_ready`=1, `busy`=0, `done`=0, `err`=0.
  - FSM returns to IDLE, counters clear.
  - Reset applied mid-command aborts the command with no `done`.
- FSM states: IDLE, HOLD, RELEASE, FINISH.
- IDLE:
  - `cmd_ready`=1.
  - Accept occurs on `cmd_valid && cmd_ready` at an edge. The block latches the op, the mask, and `H = max(cmd_hold, MIN_HOLD)`.
- PULSE:
  - Sets `core_reset[i]` for every masked i, then moves to HOLD and counts H cycles.
  - Then moves to RELEASE with pending set = mask.
- ASSERT:
  - Sets masked bits of `core_reset`. Unmasked bits are unchanged.
  - Then moves to FINISH.
- RELEASE:
  - Pending set = mask AND current `core_reset`. Cores that are already out of reset are skipped and consume no slot.
  - While in RELEASE, the block clears the lowest-index pending bit, then waits STAGGER cycles before clearing the next.
  - `done` pulses in the cycle the last pending bit clears, and the FSM returns to IDLE.
- Empty pending set (mask=0, or RELEASE with nothing asserted): the block goes via FINISH and `done` pulses the cycle after accept.
- Illegal op (3): the command is accepted, has no effect on `core_reset`, and `err` and `done` both pulse the cycle after accept.
- Bits of `core_reset` outside the current mask never change while a command is in progress.
- Counters:
  - Hold counter is `HOLD_W` bits.
  - Stagger counter is `$clog2(STAGGER+1)` bits.
  - Neither counter wraps; each saturates at its load value and decrements to 0.

## Timing
Accept edge = cycle T.
- `cmd_ready` falls at T+1 and stays low until the cycle after `done`.
- PULSE:
  - Masked bits are 1 from T+1 through T+H.
  - The first release is at T+H+1; the k-th masked core (k from 0) releases at T+H+1+k·STAGGER.
  - `done` pulses with the last release, and `cmd_ready` rises the next cycle.
- ASSERT: masked bits are 1 at T+1; `done` pulses at T+1; `cmd_ready` rises at T+2.
- RELEASE: the k-th pending core releases at T+1+k·STAGGER, and `done` pulses with the last release.
- Back-to-back commands: with `cmd_valid` held, the next accept is at the first edge where `cmd_ready`=1. Successive accepts are therefore at least 2 cycles apart.
- `cmd_*` inputs are sampled only at the accept edge; changes at any other time are ignored.
- All outputs are registered except `cmd_ready` and `busy`, which decode directly from FSM state.

## Test plan
Parameters for all scenarios: NUM_CORES=4, MIN_HOLD=8, STAGGER=2.
1. Power-on release:
   - `reset_n` low for 3 cycles, giving `core_reset`=4'b1111 and `cmd_ready`=1.
   - RELEASE mask=4'b1111 accepted at T.
   - Cores 0/1/2/3 release at T+1/T+3/T+5/T+7, `done` pulses at T+7, `cmd_ready`=1 at T+8.
2. Pulse with short hold:
   - From all-released, PULSE mask=4'b0101, hold=3 (H=8).
   - Bits 0 and 2 are 1 over T+1..T+8, bit 0 clears at T+9, bit 2 clears at T+11, `done` pulses at T+11.
   - Bits 1 and 3 stay 0 throughout.
3. Pulse with long hold: PULSE mask=4'b1000, hold=20 gives bit 3 = 1 over T+1..T+20, cleared at T+21 with `done`.
4. Skip and empty:
   - ASSERT mask=4'b0010, then RELEASE mask=4'b0011: only core 1 releases, at T+1, with `done` at T+1.
   - RELEASE mask=0 gives `done` at T+1 and no change to `core_reset`.
5. Illegal op and mid-command reset:
   - `cmd_op`=3 gives `err`+`done` at T+1 with `core_reset` unchanged.
   - `reset_n` low during the HOLD of a PULSE gives `core_reset`=4'b1111, no `done`, and `cmd_ready`=1 after reset.
